// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch program counter with redirect, flush and halt sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] jump_imm26,
    input  logic [15:0] br_off16,
    input  logic [31:0] reg_target,
    input  logic        halt_req,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        flush,
    output logic        halted,
    output logic        err_pulse,
    output logic [15:0] redirect_count
);

    localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_fcnt, w_fcnt_nx;
    logic [31:0] w_pc_nx, w_target;
    logic        w_valid_nx, w_flush_nx, w_halted_nx, w_err_nx;
    logic [15:0] w_count_nx;
    logic        w_type_legal, w_take, w_redir_err;

    // Target computation is purely a function of the redirect inputs.
    always_comb begin
        w_target     = '0;
        w_type_legal = 1'b1;
        case (redirect_type)
            2'b00:   w_target = {redirect_pc[31:28], jump_imm26, 2'b00};
            2'b01:   w_target = redirect_pc + {{14{br_off16[15]}}, br_off16, 2'b00};
            2'b10:   w_target = {reg_target[31:2], 2'b00};
            default: w_type_legal = 1'b0;
        endcase
        w_take      = redirect_valid && w_type_legal;
        w_redir_err = redirect_valid &&
                      (!w_type_legal || (redirect_type == 2'b10 && reg_target[1:0] != 2'b00));
    end

    always_comb begin
        w_state_nx  = r_state;
        w_fcnt_nx   = r_fcnt;
        w_pc_nx     = pc_out;
        w_valid_nx  = pc_valid;
        w_flush_nx  = flush;
        w_halted_nx = halted;
        w_err_nx    = 1'b0;
        w_count_nx  = redirect_count;
        case (r_state)
            S_IDLE: begin
                w_state_nx = S_FETCH;
                w_valid_nx = 1'b1;
            end
            S_FETCH, S_FLUSH: begin
                w_err_nx = w_redir_err;
                if (w_take) begin
                    // Accepted in both states; a redirect in FLUSH restarts the flush window.
                    w_pc_nx    = w_target;
                    w_state_nx = S_FLUSH;
                    w_flush_nx = 1'b1;
                    w_valid_nx = 1'b0;
                    w_fcnt_nx  = c_flush_load;
                    if (redirect_count != 16'hFFFF)
                        w_count_nx = redirect_count + 16'd1;
                end else if (r_state == S_FLUSH) begin
                    w_fcnt_nx = r_fcnt - 4'd1;
                    if (r_fcnt <= 4'd1) begin
                        w_fcnt_nx  = 4'd0;
                        w_state_nx = S_FETCH;
                        w_flush_nx = 1'b0;
                        w_valid_nx = 1'b1;
                    end
                end else if (halt_req) begin
                    w_state_nx  = S_HALTED;
                    w_valid_nx  = 1'b0;
                    w_halted_nx = 1'b1;
                end else if (fetch_ready) begin
                    w_pc_nx = pc_out + 32'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_fcnt         <= 4'd0;
            pc_out         <= RESET_PC;
            pc_valid       <= 1'b0;
            flush          <= 1'b0;
            halted         <= 1'b0;
            err_pulse      <= 1'b0;
            redirect_count <= 16'd0;
        end else begin
            r_state        <= w_state_nx;
            r_fcnt         <= w_fcnt_nx;
            pc_out         <= w_pc_nx;
            pc_valid       <= w_valid_nx;
            flush          <= w_flush_nx;
            halted         <= w_halted_nx;
            err_pulse      <= w_err_nx;
            redirect_count <= w_count_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed scoreboard bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_type = 2'b00;
    logic [31:0] redirect_pc = '0;
    logic [25:0] jump_imm26 = '0;
    logic [15:0] br_off16 = '0;
    logic [31:0] reg_target = '0;
    logic        halt_req = 1'b0;
    logic [31:0] pc_out;
    logic        pc_valid, flush, halted, err_pulse;
    logic [15:0] redirect_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flsh;
        logic        hlt;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];

    pc_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_type  (redirect_type),
        .redirect_pc    (redirect_pc),
        .jump_imm26     (jump_imm26),
        .br_off16       (br_off16),
        .reg_target     (reg_target),
        .halt_req       (halt_req),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .halted         (halted),
        .err_pulse      (err_pulse),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Push the outputs expected after the next edge, then clock and compare.
    task automatic step(input string tag, input logic [31:0] pc, input logic v,
                        input logic f, input logic h, input logic e, input logic [15:0] c);
        exp_t  ex;
        string t;
        expq.push_back({pc, v, f, h, e, c});
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        ex = expq.pop_front();
        t  = tagq.pop_front();
        chk({t, ".pc"},    pc_out,         ex.pc);
        chk({t, ".valid"}, 32'(pc_valid),  32'(ex.valid));
        chk({t, ".flush"}, 32'(flush),     32'(ex.flsh));
        chk({t, ".halt"},  32'(halted),    32'(ex.hlt));
        chk({t, ".err"},   32'(err_pulse), 32'(ex.err));
        chk({t, ".count"}, 32'(redirect_count), 32'(ex.cnt));
    endtask

    task automatic redir(input logic [1:0] ty, input logic [31:0] base,
                         input logic [25:0] imm, input logic [15:0] off, input logic [31:0] rt);
        redirect_valid = 1'b1;
        redirect_type  = ty;
        redirect_pc    = base;
        jump_imm26     = imm;
        br_off16       = off;
        reg_target     = rt;
    endtask

    initial begin
        // Reset, IDLE, sequential fetch, stall
        rst = 1'b1; fetch_ready = 1'b1;
        step("reset",      32'h0, 0, 0, 0, 0, 16'd0);
        rst = 1'b0;
        step("idle",       32'h0, 1, 0, 0, 0, 16'd0);
        step("adv4",       32'h4, 1, 0, 0, 0, 16'd0);
        step("adv8",       32'h8, 1, 0, 0, 0, 16'd0);
        step("adv12",      32'hC, 1, 0, 0, 0, 16'd0);
        fetch_ready = 1'b0;
        step("stall",      32'hC, 1, 0, 0, 0, 16'd0);

        // Jump absolute
        redir(2'b00, 32'hA000_0010, 26'h123, 16'h0, 32'h0);
        step("jmp",        32'hA000_048C, 0, 1, 0, 0, 16'd1);
        redirect_valid = 1'b0;
        step("jmp_fl2",    32'hA000_048C, 0, 1, 0, 0, 16'd1);
        step("jmp_back",   32'hA000_048C, 1, 0, 0, 0, 16'd1);

        // Branch relative, negative then positive offset
        redir(2'b01, 32'h0000_1000, 26'h0, 16'hFFFF, 32'h0);
        step("brneg",      32'h0000_0FFC, 0, 1, 0, 0, 16'd2);
        redirect_valid = 1'b0;
        step("brneg_fl2",  32'h0000_0FFC, 0, 1, 0, 0, 16'd2);
        step("brneg_back", 32'h0000_0FFC, 1, 0, 0, 0, 16'd2);
        redir(2'b01, 32'h0000_1000, 26'h0, 16'h0004, 32'h0);
        step("brpos",      32'h0000_1010, 0, 1, 0, 0, 16'd3);
        redirect_valid = 1'b0;
        step("brpos_fl2",  32'h0000_1010, 0, 1, 0, 0, 16'd3);
        step("brpos_back", 32'h0000_1010, 1, 0, 0, 0, 16'd3);

        // Misaligned register target: taken, single err pulse
        redir(2'b10, 32'h0, 26'h0, 16'h0, 32'h0000_2003);
        step("regmis",     32'h0000_2000, 0, 1, 0, 1, 16'd4);
        redirect_valid = 1'b0;
        step("regmis_fl2", 32'h0000_2000, 0, 1, 0, 0, 16'd4);
        step("regmis_back",32'h0000_2000, 1, 0, 0, 0, 16'd4);

        // Reserved type: err pulse, advance still happens, count unchanged
        redir(2'b11, 32'h0, 26'h0, 16'h0, 32'h0);
        fetch_ready = 1'b1;
        step("rsv",        32'h0000_2004, 1, 0, 0, 1, 16'd4);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        step("rsv_after",  32'h0000_2004, 1, 0, 0, 0, 16'd4);

        // Redirect on the first FLUSH cycle restarts the window
        redir(2'b01, 32'h0000_0100, 26'h0, 16'h0, 32'h0);
        step("br0",        32'h0000_0100, 0, 1, 0, 0, 16'd5);
        redir(2'b10, 32'h0, 26'h0, 16'h0, 32'h0000_3000);
        step("reredir",    32'h0000_3000, 0, 1, 0, 0, 16'd6);
        redirect_valid = 1'b0;
        step("reredir_fl", 32'h0000_3000, 0, 1, 0, 0, 16'd6);
        step("reredir_bk", 32'h0000_3000, 1, 0, 0, 0, 16'd6);

        // PC wrap at the top of the address space
        redir(2'b10, 32'h0, 26'h0, 16'h0, 32'hFFFF_FFFC);
        step("top",        32'hFFFF_FFFC, 0, 1, 0, 0, 16'd7);
        redirect_valid = 1'b0;
        step("top_fl2",    32'hFFFF_FFFC, 0, 1, 0, 0, 16'd7);
        step("top_back",   32'hFFFF_FFFC, 1, 0, 0, 0, 16'd7);
        fetch_ready = 1'b1;
        step("wrap",       32'h0, 1, 0, 0, 0, 16'd7);
        fetch_ready = 1'b0;

        // Redirect beats halt; halt ignored in FLUSH, taken back in FETCH
        halt_req = 1'b1;
        redir(2'b00, 32'h0, 26'h10, 16'h0, 32'h0);
        step("halt_vs_rd", 32'h40, 0, 1, 0, 0, 16'd8);
        redirect_valid = 1'b0;
        step("halt_infl",  32'h40, 0, 1, 0, 0, 16'd8);
        step("halt_flend", 32'h40, 1, 0, 0, 0, 16'd8);
        step("halted",     32'h40, 0, 0, 1, 0, 16'd8);

        // HALTED ignores everything except reset
        halt_req = 1'b0; fetch_ready = 1'b1;
        redir(2'b00, 32'h0, 26'h20, 16'h0, 32'h0);
        step("hlt_ign_rd", 32'h40, 0, 0, 1, 0, 16'd8);
        redirect_type = 2'b11;
        step("hlt_ign_rs", 32'h40, 0, 0, 1, 0, 16'd8);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        rst = 1'b1;
        step("rst_hlt",    32'h0, 0, 0, 0, 0, 16'd0);
        rst = 1'b0;
        step("rst_hlt_f",  32'h0, 1, 0, 0, 0, 16'd0);

        // Reset in the middle of a flush
        redir(2'b00, 32'h0, 26'h40, 16'h0, 32'h0);
        step("pre_rst",    32'h100, 0, 1, 0, 0, 16'd1);
        redirect_valid = 1'b0; rst = 1'b1;
        step("rst_flush",  32'h0, 0, 0, 0, 0, 16'd0);
        rst = 1'b0; fetch_ready = 1'b1;
        step("rst_fl_idle",32'h0, 1, 0, 0, 0, 16'd0);
        step("rst_fl_adv", 32'h4, 1, 0, 0, 0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter and sequences all control-flow redirects.
- Builds jump targets by shifting the 26-bit immediate left by two into 28 bits and prefixing the upper 4 PC bits.
- Also computes branch and register targets, drives a fixed-length pipeline flush after each redirect, and handles halt.
- Sits between the execute-stage control-flow resolver and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush is held high after an accepted redirect (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_ready  input  1  instruction memory accepts pc_out this cycle.
- redirect_valid  input  1  execute stage requests a control-flow change.
- redirect_type  input  2  00 jump-absolute, 01 branch-relative, 10 register, 11 reserved.
- redirect_pc  input  32  PC+4 of the redirecting instruction (base address).
- jump_imm26  input  26  jump immediate (type 00).
- br_off16  input  16  signed word offset (type 01).
- reg_target  input  32  register target (type 10).
- halt_req  input  1  stop fetching.
- pc_out  output  32  current fetch address.
- pc_valid  output  1  pc_out is a valid fetch request.
- flush  output  1  kill younger in-flight instructions.
- halted  output  1  sequencer is in HALTED.
- err_pulse  output  1  one-cycle pulse on a reserved type or misaligned register target.
- redirect_count  output  16  number of accepted redirects, saturating at 16'hFFFF.

Behaviour:
- Reset (rst high at clock edge) from any state, including mid-flush:
  - state to IDLE, pc_out to RESET_PC.
  - pc_valid, flush, halted and err_pulse to 0.
  - redirect_count to 0, flush counter to 0.
- States are IDLE, FETCH, FLUSH and HALTED. All outputs are registered.
- IDLE: lasts exactly one cycle after reset deassertion, then goes to FETCH with pc_valid=1.
- FETCH: pc_valid=1. Each cycle, the first matching rule below applies:
  1. redirect_valid with a legal type: load the target into pc_out; go to FLUSH with flush=1 and pc_valid=0; load the counter with FLUSH_CYCLES; increment redirect_count.
  2. halt_req: go to HALTED; pc_out holds; pc_valid=0; halted=1.
  3. fetch_ready: pc_out <= pc_out + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  4. Otherwise: hold pc_out (stall).
- FLUSH: flush=1 and pc_valid=0; the counter decrements each cycle. When it reaches 0, flush drops and the block returns to FETCH with pc_valid=1 on the same edge. flush is therefore high for exactly FLUSH_CYCLES cycles.
- Redirect during FLUSH: accepted. Target replaces pc_out, the counter reloads to FLUSH_CYCLES, redirect_count increments.
- halt_req during FLUSH is ignored; it is re-sampled in FETCH.
- HALTED: pc_valid=0, halted=1, all inputs ignored. Only rst exits this state.
- Target arithmetic (combinational from inputs, registered into pc_out):
  - type 00: {redirect_pc[31:28], jump_imm26, 2'b00}.
  - type 01: redirect_pc + {{14{br_off16[15]}}, br_off16, 2'b00}, modulo 2^32.
  - type 10: {reg_target[31:2], 2'b00}. If reg_target[1:0] != 0, err_pulse=1 for one cycle; the redirect is still taken.
- Reserved type 11: no redirect, no count increment, err_pulse=1 for one cycle. Lower-priority rules (halt, advance) still apply that cycle.
- err_pulse is 0 in every other case. The count does not wrap; it stays at 16'hFFFF once reached.

Test Plan:
- Reset, then fetch_ready held at 1 for 4 cycles -> pc_out=0 with pc_valid=0 for one cycle (IDLE), then pc_out = 0, 4, 8, 12 on successive cycles. Drop fetch_ready -> pc_out holds at 12.
- FETCH, type 00, redirect_pc=32'hA000_0010, jump_imm26=26'h123 -> pc_out=32'hA000_048C. flush=1 and pc_valid=0 for exactly 2 cycles, then pc_valid=1. redirect_count=1.
- Type 01, redirect_pc=32'h0000_1000, br_off16=16'hFFFF -> pc_out=32'h0000_0FFC. Repeat with br_off16=16'h0004 -> pc_out=32'h0000_1010.
- Type 10, reg_target=32'h0000_2003 -> pc_out=32'h0000_2000 and a single-cycle err_pulse. Then type 11 with fetch_ready=1 -> err_pulse, PC advances by 4, count unchanged.
- Second redirect (type 10, reg_target=32'h0000_3000) on the first FLUSH cycle -> pc_out=32'h0000_3000, flush stays high 2 more cycles (3 in total), count +2. Assert halt_req with redirect_valid in the same FETCH cycle -> redirect wins; halt is taken in the first FETCH cycle after the flush, leaving halted=1 and pc_valid=0.
- rst asserted mid-FLUSH and while HALTED -> next cycle pc_out=RESET_PC, flush=0, halted=0, redirect_count=0, IDLE then FETCH.
